// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module  : serial_parity_rx
// Desc    : Oversampled start/data/parity/stop receiver, valid/ready output,
//           sticky frame/overrun flags. Define RX_SYNC_EN for a 2-flop rx sync.
// Revision: 1.0
// ============================================================================

module serial_parity_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OS         = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int TW = $clog2(OS);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] TICK_FULL = TW'(OS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          ODD       = (ODD_PARITY != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic                 rx_s;
  logic [DATA_BITS-1:0] shift_in;
  logic                 load;
  logic                 set_ferr;
  logic                 set_ovr;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  // First bit received must end up in data[0], so samples enter at the MSB.
  generate
    if (DATA_BITS == 1) begin : g_shift_one
      assign shift_in = rx_s;
    end else begin : g_shift_many
      assign shift_in = {rx_s, shift_q[DATA_BITS-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      shift_q     <= '0;
      acc_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    perr_pend_d = perr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;
    load        = 1'b0;
    set_ferr    = 1'b0;
    set_ovr     = 1'b0;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tcnt_d  = '0;
            acc_d   = 1'b0;
          end
        end
        START: begin
          if (tcnt_q == TICK_HALF) begin
            tcnt_d = '0;
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              bcnt_d  = '0;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tcnt_q == TICK_FULL) begin
            tcnt_d  = '0;
            shift_d = shift_in;
            acc_d   = acc_q ^ rx_s;
            if (bcnt_q == BIT_LAST) begin
              state_d = PARITY;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tcnt_q == TICK_FULL) begin
            tcnt_d      = '0;
            perr_pend_d = ((acc_q ^ rx_s) != ODD);
            state_d     = STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        STOP: begin
          if (tcnt_q == TICK_FULL) begin
            tcnt_d = '0;
            if (rx_s) begin
              load    = 1'b1;
              state_d = IDLE;
            end else begin
              set_ferr = 1'b1;
              state_d  = BREAK;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A completing word may replace the held one only if it is consumed on this edge.
    if (load) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        perr_d  = perr_pend_q;
        valid_d = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end

    if (err_clr) begin
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (set_ferr) begin
      ferr_d = 1'b1;
    end
    if (set_ovr) begin
      ovr_d = 1'b1;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// Directed bench: an even-parity receiver and an odd-parity twin share one serial line.

module tb_serial_parity_rx;

  localparam int OS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic       ready_odd = 1'b1;

  logic [7:0] data;
  logic       data_valid, parity_err, frame_err, overrun, busy;
  logic [7:0] data_o;
  logic       valid_o, perr_o, ferr_o, ovr_o, busy_o;

  int         n_vec = 0;
  int         n_err = 0;
  int         lat;
  logic       busy_at_valid;
  logic [7:0] w;

  serial_parity_rx #(.DATA_BITS(8), .OS(OS), .ODD_PARITY(0)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .err_clr(err_clr), .busy(busy)
  );

  serial_parity_rx #(.DATA_BITS(8), .OS(OS), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data(data_o), .data_valid(valid_o), .data_ready(ready_odd),
    .parity_err(perr_o), .frame_err(ferr_o), .overrun(ovr_o),
    .err_clr(err_clr), .busy(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS) @(negedge clk);
  endtask

  // Whole frame; stop bit loop records cycles until data_valid and optionally
  // raises data_ready across the stop-sample edge.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input logic rdy);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
    rx = stop;
    lat = 0;
    busy_at_valid = 1'b1;
    for (int i = 0; i < OS; i++) begin
      data_ready = (i == OS / 2) ? rdy : 1'b0;
      @(negedge clk);
      if (lat == 0 && data_valid) begin
        lat = i + 1;
        busy_at_valid = busy;
      end
    end
    data_ready = 1'b0;
  endtask

  task automatic pulse_ready();
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_odd_busy", busy_o, 1'b0);
    chk("rst_odd_valid", valid_o, 1'b0);
    rst_n = 1'b1;
    idle(4);

    tick = 1'b0;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("tick0_no_start", busy, 1'b0);
    rx = 1'b1;
    tick = 1'b1;
    idle(2);

    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    chk("a5_latency", lat, 5);
    chk("a5_busy_at_valid", busy_at_valid, 1'b0);
    chk("a5_data", data, 8'hA5);
    chk("a5_perr", parity_err, 1'b0);
    chk("a5_ferr", frame_err, 1'b0);
    chk("a5_odd_perr", perr_o, 1'b1);
    idle(10);
    chk("a5_valid_held", data_valid, 1'b1);
    pulse_ready();
    chk("a5_valid_drop", data_valid, 1'b0);
    chk("a5_data_kept", data, 8'hA5);

    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    chk("p01_data", data, 8'h01);
    chk("p01_perr", parity_err, 1'b1);
    chk("p01_ferr", frame_err, 1'b0);
    chk("p01_valid", data_valid, 1'b1);
    chk("p01_odd_perr", perr_o, 1'b0);
    pulse_ready();
    idle(2);

    rx = 1'b0;
    repeat (2) @(negedge clk);
    chk("fs_busy_in_start", busy, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    chk("fs_busy", busy, 1'b0);
    chk("fs_valid", data_valid, 1'b0);
    chk("fs_ferr", frame_err, 1'b0);
    chk("fs_ovr", overrun, 1'b0);

    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("fe_ferr", frame_err, 1'b1);
    chk("fe_odd_ferr", ferr_o, 1'b1);
    chk("fe_valid", data_valid, 1'b0);
    chk("fe_data_untouched", data, 8'h01);
    chk("fe_break_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("fe_break_exit", busy, 1'b0);
    pulse_clr();
    chk("fe_clr", frame_err, 1'b0);
    idle(4);

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("ov_data_old", data, 8'h3C);
    chk("ov_valid", data_valid, 1'b1);
    chk("ov_flag", overrun, 1'b1);
    chk("ov_odd_flag", ovr_o, 1'b0);
    pulse_clr();
    chk("ov_clr", overrun, 1'b0);
    chk("ov_valid_after_clr", data_valid, 1'b1);
    pulse_ready();
    chk("ov_valid_drop", data_valid, 1'b0);
    idle(4);

    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
    chk("rdy_data_new", data, 8'hC3);
    chk("rdy_valid", data_valid, 1'b1);
    chk("rdy_no_ovr", overrun, 1'b0);

    w = 8'h5A;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(w[i]);
    rx = w[4];
    repeat (2) @(negedge clk);
    chk("mr_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_data", data, 8'h00);
    chk("mr_valid", data_valid, 1'b0);
    chk("mr_perr", parity_err, 1'b0);
    chk("mr_ferr", frame_err, 1'b0);
    chk("mr_ovr", overrun, 1'b0);
    chk("mr_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(10);
    chk("mr_idle_after", busy, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("mr_5a_latency", lat, 5);
    chk("mr_5a_data", data, 8'h5A);
    chk("mr_5a_perr", parity_err, 1'b0);
    pulse_ready();
    idle(2);

    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    chk("odd_p1_data", data_o, 8'h00);
    chk("odd_p1_perr", perr_o, 1'b0);
    chk("even_p1_perr", parity_err, 1'b1);
    pulse_ready();
    idle(2);
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    chk("odd_p0_perr", perr_o, 1'b1);
    chk("even_p0_perr", parity_err, 1'b0);
    pulse_ready();
    chk("end_valid", data_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Serial frame receiver: start bit, DATA_BITS data bits (LSB first), one parity bit, one stop bit; line idles high.
- Receiving end of the team's XOR-based parity generator/transmitter path.
- Oversamples the line with a tick strobe, recomputes parity by XOR accumulation, and presents each word on a valid/ready handshake with error flags.

Parameters:
- DATA_BITS, 8, number of data bits per frame (1..16).
- OS, 8, tick strobes per bit period (even, >=4).
- ODD_PARITY, 0, 0 = even parity expected, 1 = odd parity expected.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tick  input  1  oversample strobe; counters advance only on clk edges with tick=1.
- rx  input  1  serial line, idle high.
- data  output  DATA_BITS  received word; held stable while data_valid=1.
- data_valid  output  1  word available.
- data_ready  input  1  consumer accepts data on an edge where data_valid=1 and data_ready=1.
- parity_err  output  1  parity mismatch for the word currently in data; loaded together with data.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a frame completed while the previous word was unconsumed.
- err_clr  input  1  synchronous clear of frame_err and overrun.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; data, data_valid, parity_err, frame_err and overrun all 0; busy=0.
  - Tick counter, bit counter and shift register cleared.
  - Reset asserted mid-frame abandons the frame with no output.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a tick with rx=0, go to START, clear tick counter and clear the parity accumulator.
- START: after OS/2 ticks, sample rx.
  - rx=1: false start; return to IDLE with no flags.
  - rx=0: go to DATA with bit counter=0.
- DATA:
  - Every OS ticks, sample rx at mid-bit.
  - Shift the sample in at the MSB side so the first bit received ends in data[0].
  - XOR the sample into the accumulator.
  - After DATA_BITS samples, go to PARITY.
- PARITY: after OS ticks, sample rx; error = (acc XOR rx) != ODD_PARITY; go to STOP.
- STOP: after OS ticks, sample rx.
  - rx=1, word loaded: data, parity_err and data_valid=1 update on the same edge; go to IDLE.
  - rx=0: set frame_err; discard the word (data, parity_err and data_valid untouched); go to BREAK.
- BREAK: wait for any tick with rx=1, then go to IDLE. This prevents restart storms on a line stuck low.
- Latency: data_valid rises on the edge of the tick that samples the stop bit.
- Handshake:
  - data_valid stays 1 until an edge with data_ready=1, then falls.
  - data_ready while data_valid=0 is ignored.
- New word arrives while data_valid=1:
  - If data_ready=1 on that same edge: the new word is loaded, data_valid stays 1, no overrun.
  - Otherwise: overrun is set, the old data and parity_err are kept, and the new word is dropped.
- err_clr clears frame_err and overrun. If err_clr coincides with a new set event, set wins.
- tick=0 freezes all counters; rx is sampled only on tick edges.

Optional Feature:
- Macro RX_SYNC_EN.
- Defined: rx passes through a two-flop synchronizer (both flops reset to 1) before use. Every rx-to-state response is delayed by 2 clk.
- Undefined: rx is used directly; the caller guarantees it is synchronous to clk.

Test Plan:
- Good frame, tick=1 constant, OS=8, word 0xA5:
  - Stimulus: start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1.
  - Response: data=0xA5, parity_err=0, data_valid=1 until data_ready pulse, busy falls with data_valid rise.
- Parity error: word 0x01 sent with parity bit 0 (even mode) -> data=0x01, parity_err=1, frame_err=0.
- False start and frame error:
  - rx low for 2 ticks, then high -> back to IDLE, no flags.
  - Frame with stop=0 -> frame_err=1, data_valid stays 0, FSM in BREAK until rx=1.
  - err_clr -> frame_err=0.
- Overrun:
  - Two back-to-back frames 0x3C then 0xC3 with data_ready=0 -> data=0x3C, overrun=1.
  - Repeat with data_ready=1 on the second completion edge -> data=0xC3, overrun=0.
- Reset mid-DATA at bit 4: rst_n low 1 cycle -> all outputs 0, IDLE; next full frame 0x5A received correctly.
- ODD_PARITY=1, word 0x00 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
